// File: rtl/dcache_store_drain.sv
// dcache_store_drain: buffers core stores in a FIFO and drains them into the shared word SRAM.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   wvalid_i/wready_o/waddr_i/
//   wdata_i/wstrb_i                  core store port (byte address, lane-aligned data, byte enables)
//   mem_req_o/mem_gnt_i/mem_we_o/
//   mem_addr_o/mem_wdata_o/
//   mem_rdata_i                      arbitrated single-port SRAM (read data one cycle after granted read)
//   chk_addr_i/chk_hit_o             load hazard check against pending and in-flight stores
//   empty_o                          nothing buffered and no store in flight (fence drain)
module dcache_store_drain #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32,
   parameter int XLEN       = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic [XLEN-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic [XLEN-1:0]         chk_addr_i,
   output logic                    chk_hit_o,
   output logic                    empty_o
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;
   logic [ADDR_WIDTH-1:0] r_faddr [DEPTH];
   logic [DATA_WIDTH-1:0] r_fdata [DEPTH];
   logic [SW-1:0]         r_fstrb [DEPTH];
   logic [PW-1:0]         r_wptr, r_rptr;
   logic [CW-1:0]         r_count;
   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [SW-1:0]         r_strb;
   logic                  r_req, r_we;
   logic [DATA_WIDTH-1:0] r_mwdata;
   logic                  w_push, w_pop;
   logic [ADDR_WIDTH-1:0] w_waddr, w_chk_word;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DEPTH-1:0]      w_hits;
   logic                  w_unused;
   // address bits outside the SRAM word index are intentionally dropped
   assign w_unused   = ^{waddr_i, chk_addr_i};
   assign w_waddr    = waddr_i[ADDR_WIDTH+1:2];
   assign w_chk_word = chk_addr_i[ADDR_WIDTH+1:2];
   assign wready_o   = r_count != CW'(DEPTH);
   // zero-strobe stores are acknowledged but never enter the FIFO
   assign w_push     = wvalid_i & wready_o & (|wstrb_i);
   assign w_pop      = (r_state == IDLE) && (r_count != '0);
   assign mem_req_o   = r_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_mwdata;
   assign empty_o     = (r_count == '0) && (r_state == IDLE);
   for (genvar i = 0; i < SW; i++) begin : g_mask
      assign w_mask[i*8 +: 8] = {8{r_strb[i]}};
   end
   // an entry is live when its distance from the read pointer is below count
   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign w_hits[i] = ({1'b0, PW'(i) - r_rptr} < r_count) && (r_faddr[i] == w_chk_word);
   end
   assign chk_hit_o = (|w_hits) | ((r_state != IDLE) && (r_addr == w_chk_word));
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_faddr[r_wptr] <= w_waddr;
         r_fdata[r_wptr] <= wdata_i;
         r_fstrb[r_wptr] <= wstrb_i;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
   // request outputs are registered and only change on grant, so they hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_data   <= '0;
         r_strb   <= '0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_mwdata <= '0;
      end else begin
         case (r_state)
            IDLE: if (r_count != '0) begin
               r_addr   <= r_faddr[r_rptr];
               r_data   <= r_fdata[r_rptr];
               r_strb   <= r_fstrb[r_rptr];
               r_mwdata <= r_fdata[r_rptr];
               r_req    <= 1'b1;
               r_we     <= &r_fstrb[r_rptr];
               r_state  <= (&r_fstrb[r_rptr]) ? WR : RD;
            end
            RD: if (mem_gnt_i) begin
               r_req   <= 1'b0;
               r_state <= WAIT;
            end
            WAIT: begin
               r_mwdata <= (mem_rdata_i & ~w_mask) | (r_data & w_mask);
               r_req    <= 1'b1;
               r_we     <= 1'b1;
               r_state  <= WR;
            end
            WR: if (mem_gnt_i) begin
               r_req   <= 1'b0;
               r_we    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_store_drain.sv
// tb_dcache_store_drain: directed bench for the store drain buffer with a behavioural SRAM.
module tb_dcache_store_drain;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wvalid_i = 1'b0;
   logic        wready_o;
   logic [31:0] waddr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  wstrb_i = '0;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_we_o;
   logic [19:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic [31:0] chk_addr_i = '0;
   logic        chk_hit_o;
   logic        empty_o;
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] sram [0:1023];
   logic [19:0] wq_addr [$];
   logic [31:0] wq_data [$];
   int          wq_cyc [$];
   dcache_store_drain #(.DEPTH(4), .ADDR_WIDTH(20), .DATA_WIDTH(32), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .wvalid_i(wvalid_i), .wready_o(wready_o), .waddr_i(waddr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .chk_addr_i(chk_addr_i), .chk_hit_o(chk_hit_o), .empty_o(empty_o)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (mem_req_o && mem_gnt_i) begin
         if (mem_we_o) begin
            sram[mem_addr_o[9:0]] = mem_wdata_o;
            wq_addr.push_back(mem_addr_o);
            wq_data.push_back(mem_wdata_o);
            wq_cyc.push_back(cyc);
         end else mem_rdata_i <= sram[mem_addr_o[9:0]];
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask
   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int ca);
      waddr_i = a;
      wdata_i = d;
      wstrb_i = s;
      wvalid_i = 1'b1;
      tick();
      ca = cyc;
      wvalid_i = 1'b0;
      wstrb_i = '0;
   endtask
   task automatic wait_idle(input string name);
      int n = 0;
      while (!empty_o && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (empty_o !== 1'b1) begin errors++; $display("FAIL %s_drain_timeout empty_o=%0b exp=1", name, empty_o); end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks += 7;
      if (wready_o !== 1'b1) begin errors++; $display("FAIL reset_wready got=%0b exp=1", wready_o); end
      if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", mem_req_o); end
      if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", mem_we_o); end
      if (mem_addr_o !== 20'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
      if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
      if (chk_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0b exp=0", chk_hit_o); end
      if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty_o); end
      rst = 1'b0;
      tick();
   endtask
   task automatic test_full_word();
      int ca;
      clear_log();
      mem_gnt_i = 1'b1;
      sram[10'h40] = 32'h0;
      push(32'h100, 32'hDEADBEEF, 4'hF, ca);
      checks++;
      if (empty_o !== 1'b0) begin errors++; $display("FAIL full_empty_fall got=%0b exp=0", empty_o); end
      wait_idle("full");
      checks++;
      if (wq_addr.size() != 1) begin errors++; $display("FAIL full_count got=%0d exp=1", wq_addr.size()); end
      if (wq_addr.size() >= 1) begin
         checks += 3;
         if (wq_addr[0] !== 20'h40) begin errors++; $display("FAIL full_addr got=%h exp=00040", wq_addr[0]); end
         if (wq_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL full_data got=%h exp=deadbeef", wq_data[0]); end
         if (wq_cyc[0] - ca != 2) begin errors++; $display("FAIL full_latency got=%0d exp=2", wq_cyc[0] - ca); end
      end
   endtask
   task automatic test_partial();
      int ca;
      clear_log();
      mem_gnt_i = 1'b1;
      sram[10'h40] = 32'h11223344;
      push(32'h100, 32'h0000AB00, 4'b0010, ca);
      wait_idle("partial");
      checks++;
      if (wq_addr.size() != 1) begin errors++; $display("FAIL partial_count got=%0d exp=1", wq_addr.size()); end
      if (wq_addr.size() >= 1) begin
         checks += 3;
         if (wq_addr[0] !== 20'h40) begin errors++; $display("FAIL partial_addr got=%h exp=00040", wq_addr[0]); end
         if (wq_data[0] !== 32'h1122AB44) begin errors++; $display("FAIL partial_data got=%h exp=1122ab44", wq_data[0]); end
         if (wq_cyc[0] - ca != 4) begin errors++; $display("FAIL partial_latency got=%0d exp=4", wq_cyc[0] - ca); end
      end
   endtask
   task automatic test_zero_strb();
      int ca;
      clear_log();
      mem_gnt_i = 1'b1;
      push(32'h100, 32'hFFFFFFFF, 4'h0, ca);
      checks++;
      if (empty_o !== 1'b1) begin errors++; $display("FAIL zero_strb_empty got=%0b exp=1", empty_o); end
      repeat (4) tick();
      checks++;
      if (wq_addr.size() != 0) begin errors++; $display("FAIL zero_strb_writes got=%0d exp=0", wq_addr.size()); end
   endtask
   task automatic test_back_to_back();
      int ca, c;
      clear_log();
      mem_gnt_i = 1'b1;
      push(32'h140, 32'hC0, 4'hF, ca);
      push(32'h144, 32'hC1, 4'hF, c);
      push(32'h148, 32'hC2, 4'hF, c);
      wait_idle("b2b");
      checks++;
      if (wq_addr.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", wq_addr.size()); end
      for (int k = 0; k < 3 && k < wq_addr.size(); k++) begin
         checks += 3;
         if (wq_addr[k] !== 20'h50 + 20'(k)) begin errors++; $display("FAIL b2b_addr%0d got=%h exp=%h", k, wq_addr[k], 20'h50 + 20'(k)); end
         if (wq_data[k] !== 32'hC0 + 32'(k)) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", k, wq_data[k], 32'hC0 + 32'(k)); end
         if (wq_cyc[k] - ca != 2 + 2 * k) begin errors++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", k, wq_cyc[k] - ca, 2 + 2 * k); end
      end
   endtask
   task automatic test_backpressure();
      int ca, acc, diffs;
      logic        s_req, s_we;
      logic [19:0] s_addr;
      logic [31:0] s_wdata;
      clear_log();
      mem_gnt_i = 1'b0;
      push(32'h200, 32'hA0, 4'hF, ca);
      tick();
      tick();
      checks += 2;
      if (mem_req_o !== 1'b1) begin errors++; $display("FAIL bp_req got=%0b exp=1", mem_req_o); end
      if (mem_we_o !== 1'b1) begin errors++; $display("FAIL bp_we got=%0b exp=1", mem_we_o); end
      acc = 0;
      wvalid_i = 1'b1;
      wstrb_i = 4'hF;
      for (int k = 0; k < 5; k++) begin
         waddr_i = 32'h204 + 32'(4 * k);
         wdata_i = 32'(k + 1);
         acc += int'(wready_o);
         tick();
      end
      wvalid_i = 1'b0;
      wstrb_i = '0;
      checks += 2;
      if (acc != 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
      if (wready_o !== 1'b0) begin errors++; $display("FAIL bp_wready got=%0b exp=0", wready_o); end
      s_req = mem_req_o;
      s_we = mem_we_o;
      s_addr = mem_addr_o;
      s_wdata = mem_wdata_o;
      diffs = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (mem_req_o !== s_req || mem_we_o !== s_we || mem_addr_o !== s_addr || mem_wdata_o !== s_wdata) diffs++;
      end
      checks += 2;
      if (diffs != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0 changes", diffs); end
      if (wq_addr.size() != 0) begin errors++; $display("FAIL bp_no_write got=%0d exp=0", wq_addr.size()); end
      mem_gnt_i = 1'b1;
      wait_idle("bp");
      checks++;
      if (wq_addr.size() != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", wq_addr.size()); end
      for (int k = 0; k < 5 && k < wq_addr.size(); k++) begin
         checks += 2;
         if (wq_addr[k] !== 20'h80 + 20'(k)) begin errors++; $display("FAIL bp_addr%0d got=%h exp=%h", k, wq_addr[k], 20'h80 + 20'(k)); end
         if (wq_data[k] !== ((k == 0) ? 32'hA0 : 32'(k))) begin errors++; $display("FAIL bp_data%0d got=%h exp=%h", k, wq_data[k], (k == 0) ? 32'hA0 : 32'(k)); end
      end
   endtask
   task automatic test_same_word();
      int ca;
      clear_log();
      mem_gnt_i = 1'b1;
      sram[10'h40] = 32'h11223344;
      push(32'h100, 32'h000000AA, 4'b0001, ca);
      push(32'h100, 32'hBB000000, 4'b1000, ca);
      wait_idle("same");
      checks++;
      if (wq_addr.size() != 2) begin errors++; $display("FAIL same_count got=%0d exp=2", wq_addr.size()); end
      if (wq_addr.size() == 2) begin
         checks += 2;
         if (wq_data[0] !== 32'h112233AA) begin errors++; $display("FAIL same_first got=%h exp=112233aa", wq_data[0]); end
         if (wq_data[1] !== 32'hBB2233AA) begin errors++; $display("FAIL same_second got=%h exp=bb2233aa", wq_data[1]); end
      end
      checks++;
      if (sram[10'h40] !== 32'hBB2233AA) begin errors++; $display("FAIL same_final got=%h exp=bb2233aa", sram[10'h40]); end
   endtask
   task automatic test_hazard();
      int ca;
      mem_gnt_i = 1'b0;
      push(32'h104, 32'h12345678, 4'hF, ca);
      chk_addr_i = 32'h106;
      #1;
      checks++;
      if (chk_hit_o !== 1'b1) begin errors++; $display("FAIL hit_fifo got=%0b exp=1", chk_hit_o); end
      chk_addr_i = 32'h108;
      #1;
      checks++;
      if (chk_hit_o !== 1'b0) begin errors++; $display("FAIL hit_other_word got=%0b exp=0", chk_hit_o); end
      chk_addr_i = 32'h00400104;
      #1;
      checks++;
      if (chk_hit_o !== 1'b1) begin errors++; $display("FAIL hit_wrap got=%0b exp=1", chk_hit_o); end
      tick();
      chk_addr_i = 32'h106;
      #1;
      checks++;
      if (chk_hit_o !== 1'b1) begin errors++; $display("FAIL hit_inflight got=%0b exp=1", chk_hit_o); end
      mem_gnt_i = 1'b1;
      wait_idle("hit");
      checks++;
      if (chk_hit_o !== 1'b0) begin errors++; $display("FAIL hit_drained got=%0b exp=0", chk_hit_o); end
   endtask
   task automatic test_reset_mid();
      int ca;
      clear_log();
      mem_gnt_i = 1'b1;
      sram[10'h40] = 32'h11223344;
      sram[10'h41] = 32'h0;
      push(32'h100, 32'h00000055, 4'b0001, ca);
      push(32'h104, 32'h99999999, 4'hF, ca);
      tick();
      checks++;
      if (empty_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", empty_o); end
      rst = 1'b1;
      #1;
      checks += 3;
      if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req got=%0b exp=0", mem_req_o); end
      if (empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%0b exp=1", empty_o); end
      if (wready_o !== 1'b1) begin errors++; $display("FAIL rstmid_wready got=%0b exp=1", wready_o); end
      tick();
      rst = 1'b0;
      repeat (8) tick();
      checks += 3;
      if (wq_addr.size() != 0) begin errors++; $display("FAIL rstmid_writes got=%0d exp=0", wq_addr.size()); end
      if (sram[10'h40] !== 32'h11223344) begin errors++; $display("FAIL rstmid_word40 got=%h exp=11223344", sram[10'h40]); end
      if (empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty_after got=%0b exp=1", empty_o); end
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) sram[i] = '0;
      test_reset();
      test_full_word();
      test_partial();
      test_zero_strb();
      test_back_to_back();
      test_backpressure();
      test_same_word();
      test_hazard();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
